kypd_sseg_event_control: RTL

- Parametrised successor to the keypad/seven-segment/UART control FSM in the basic-IO demo.
- Arbitrates the seven-segment controller between the loop-pattern generator and keypad display, and queues single-key press events into a FIFO drained by a ready-handshaked UART transmitter.
- Adds a post-release hold timeout before returning to the loop, and a multi-press count display.
- Sits between keypad decoder/counter, loop pattern generator, sseg controller and uart_tx.

---
 rtl/kypd_sseg_event_control_pkg.sv | 17 +
 rtl/bin2sseg.sv | 34 +++
 rtl/kypd_evt_fifo.sv | 50 +++++
 rtl/kypd_sseg_event_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/kypd_sseg_event_control_pkg.sv
// rtl/kypd_sseg_event_control_pkg.sv - shared types and constants for the keypad/sseg event controller
package kypd_sseg_event_control_pkg;

    // Display ownership: loop pattern generator, live key display, post-release hold.
    typedef enum logic [1:0] {
        ST_LOOP = 2'd0,
        ST_KEY  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Segment lines per digit: seven segments plus decimal point.
    localparam int SEG_W = 8;

    // Segments are active-low, so all ones is a dark digit.
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/bin2sseg.sv
// rtl/bin2sseg.sv - hex nibble to seven-segment pattern
//
// Ports:
//   bin - 4-bit value to display
//   seg - {dp, g, f, e, d, c, b, a}, active-low, decimal point off
module bin2sseg (
    input  logic [3:0] bin,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (bin)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/kypd_evt_fifo.sv
// rtl/kypd_evt_fifo.sv - synchronous event FIFO with first-word fall-through read
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data    - write strobe and data; caller must not write when full unless reading
//   rd_en, rd_data    - read strobe; rd_data shows the oldest entry whenever not empty
//   empty, full       - occupancy flags
module kypd_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Write-while-full lands in the slot being read; the read sees the old word this cycle.
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/kypd_sseg_event_control.sv
// rtl/kypd_sseg_event_control.sv - keypad/sseg display arbitration and UART key-event queue
//
// Ports:
//   clk, rst                         - clock, asynchronous active-low reset
//   num_btns, num_btns_valid         - pressed-key count sample
//   btn_row, btn_col, kypd_btn_valid - lowest pressed key sample
//   loop_data, loop_event, loop_en   - loop pattern generator interface
//   ss_idle, ss_data, ss_digit_en,
//   ss_start                         - seven-segment controller interface
//   tx_ready, tx_start, tx_data0/1   - UART transmitter interface (row, column nibbles)
//   fifo_overflow                    - sticky, an event was dropped on a full queue
module kypd_sseg_event_control
    import kypd_sseg_event_control_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int CNT_W       = 6,
    parameter int ROW_DIGIT   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CNT_W-1:0]            num_btns,
    input  logic                        num_btns_valid,
    input  logic [3:0]                  btn_row,
    input  logic [3:0]                  btn_col,
    input  logic                        kypd_btn_valid,
    input  logic [SEG_W*NUM_DIGITS-1:0] loop_data,
    input  logic                        loop_event,
    output logic                        loop_en,
    input  logic                        ss_idle,
    output logic [SEG_W*NUM_DIGITS-1:0] ss_data,
    output logic [NUM_DIGITS-1:0]       ss_digit_en,
    output logic                        ss_start,
    input  logic                        tx_ready,
    output logic                        tx_start,
    output logic [3:0]                  tx_data0,
    output logic [3:0]                  tx_data1,
    output logic                        fifo_overflow
);

    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [NUM_DIGITS-1:0] EN_DIGIT0 = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] EN_SINGLE = (NUM_DIGITS'(1) << ROW_DIGIT) | NUM_DIGITS'(1);

    state_t state, state_nxt;

    logic [CNT_W-1:0] prev_num;
    logic [3:0]       prev_row;
    logic [3:0]       prev_col;
    logic [HOLD_W-1:0] hold_cnt;

    logic accept, changed, none, single, upd, hold_done;

    logic [3:0] num_nib, lo_nib;
    logic [7:0] seg_row, seg_lo;

    logic                        int_start;
    logic [SEG_W*NUM_DIGITS-1:0] int_data;
    logic [NUM_DIGITS-1:0]       int_en;

    logic       push, pop, fifo_wr, fifo_empty, fifo_full;
    logic [7:0] fifo_rdata;

    assign accept  = num_btns_valid & kypd_btn_valid & ss_idle;
    assign changed = accept & ((btn_row != prev_row) | (btn_col != prev_col) | (num_btns != prev_num));
    assign none    = (num_btns == '0);
    assign single  = (num_btns == CNT_W'(1));
    assign hold_done = (hold_cnt == HOLD_LAST);

    // Redraw on any real change while the keypad owns the display, and always on takeover.
    assign upd = (changed & (state != ST_LOOP)) | (accept & (state == ST_LOOP) & ~none);

    if (CNT_W >= 4) begin : g_nib
        assign num_nib = num_btns[3:0];
    end else begin : g_nib_pad
        assign num_nib = {{(4 - CNT_W){1'b0}}, num_btns};
    end

    // Digit 0 shows the column for a single key, otherwise the key count.
    assign lo_nib = single ? btn_col : num_nib;

    bin2sseg u_seg_row (.bin(btn_row), .seg(seg_row));
    bin2sseg u_seg_lo  (.bin(lo_nib),  .seg(seg_lo));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_LOOP;
            prev_num <= '0;
            prev_row <= '0;
            prev_col <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                prev_num <= num_btns;
                prev_row <= btn_row;
                prev_col <= btn_col;
            end
            if (state == ST_KEY && state_nxt == ST_HOLD) begin
                hold_cnt <= '0;
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOOP: if (accept && !none) state_nxt = ST_KEY;
            ST_KEY:  if (accept && none)  state_nxt = (HOLD_CYCLES == 0) ? ST_LOOP : ST_HOLD;
            // A new press wins over an expiring hold in the same cycle.
            ST_HOLD: begin
                if (accept && !none)  state_nxt = ST_KEY;
                else if (hold_done)   state_nxt = ST_LOOP;
            end
            default: state_nxt = ST_LOOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_start <= 1'b0;
            int_data  <= '0;
            int_en    <= '0;
        end else begin
            int_start <= upd;
            if (upd) begin
                if (single) begin
                    int_data[ROW_DIGIT*SEG_W +: SEG_W] <= seg_row;
                    int_data[SEG_W-1:0]                <= seg_lo;
                    int_en                             <= EN_SINGLE;
                end else if (!none) begin
                    int_data[SEG_W-1:0] <= seg_lo;
                    int_en              <= EN_DIGIT0;
                end else begin
                    int_en <= '0;
                end
            end
        end
    end

    always_comb begin
        ss_start    = int_start;
        ss_data     = int_data;
        ss_digit_en = int_en;
        loop_en     = 1'b0;
        if (state == ST_LOOP) begin
            ss_start    = loop_event;
            ss_data     = loop_data;
            ss_digit_en = '1;
            loop_en     = 1'b1;
        end
    end

    // A pop during the tx_start cycle is blocked, giving at least two cycles between pulses.
    assign push    = changed & single;
    assign pop     = ~fifo_empty & tx_ready & ~tx_start;
    assign fifo_wr = push & (~fifo_full | pop);

    kypd_evt_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data ({btn_row, btn_col}),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_start      <= 1'b0;
            tx_data0      <= '0;
            tx_data1      <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            tx_start <= pop;
            if (pop) begin
                tx_data0 <= fifo_rdata[7:4];
                tx_data1 <= fifo_rdata[3:0];
            end
            if (push && fifo_full && !pop) fifo_overflow <= 1'b1;
        end
    end

endmodule
